// File: rtl/vga_sink_pkg.sv
// ============================================================================
//  Module      : vga_sink_pkg
//  Description : Shared types, widths and checksum step for the VGA pixel sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_sink_pkg;

    localparam int c_cnt_w   = 12;
    localparam int c_cksum_w = 32;

    typedef enum logic [0:0] {
        ST_SEEK  = 1'b0,
        ST_FRAME = 1'b1
    } sink_state_t;

    // Rotate-left by one, then fold in the 24-bit pixel.
    function automatic logic [c_cksum_w-1:0] cksum_step(input logic [c_cksum_w-1:0] acc,
                                                        input logic [23:0]          rgb);
        return {acc[c_cksum_w-2:0], acc[c_cksum_w-1]} ^ {8'h00, rgb};
    endfunction

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] cnt);
        return (cnt == {c_cnt_w{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pixel_sink_if.sv
// ============================================================================
//  Module      : vga_pixel_sink_if
//  Description : Pixel-pad bundle (strobe, syncs, blank, RGB) into the sink.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_pixel_sink_if;
    logic       pix_en_i;
    logic       hsync_pad_i;
    logic       vsync_pad_i;
    logic       blank_pad_i;
    logic [7:0] r_pad_i;
    logic [7:0] g_pad_i;
    logic [7:0] b_pad_i;

    modport master (output pix_en_i, hsync_pad_i, vsync_pad_i, blank_pad_i,
                           r_pad_i, g_pad_i, b_pad_i);
    modport slave  (input  pix_en_i, hsync_pad_i, vsync_pad_i, blank_pad_i,
                           r_pad_i, g_pad_i, b_pad_i);
endinterface

`default_nettype wire

// File: rtl/vga_sink_cksum.sv
// ============================================================================
//  Module      : vga_sink_cksum
//  Description : Per-frame rotate/XOR checksum accumulator over active pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sink_cksum
    import vga_sink_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_en,
    input  wire logic                 i_clr,
    input  wire logic [23:0]          i_rgb,
    output      logic [c_cksum_w-1:0] o_acc
);

    logic [c_cksum_w-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= cksum_step(r_acc, i_rgb);
        end
    end

    assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/vga_pixel_sink.sv
// ============================================================================
//  Module      : vga_pixel_sink
//  Description : Locks to vsync, measures frame geometry and checksums pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_sink
    import vga_sink_pkg::*;
#(
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter logic BLANK_POL  = 1'b0,
    parameter int   EXP_WIDTH  = 640,
    parameter int   EXP_HEIGHT = 480
)(
    input  wire logic                 wb_clk_i,
    input  wire logic                 wb_rst_i,
    vga_pixel_sink_if.slave           pix,
    output      logic                 frame_done_o,
    output      logic [c_cksum_w-1:0] frame_cksum_o,
    output      logic [c_cnt_w-1:0]   frame_width_o,
    output      logic [c_cnt_w-1:0]   frame_height_o,
    output      logic [c_cnt_w-1:0]   frame_hsyncs_o,
    output      logic [15:0]          frame_cnt_o,
    output      logic                 locked_o,
    output      logic                 err_width_o,
    output      logic                 err_height_o
);

    localparam logic [c_cnt_w-1:0] c_exp_w = EXP_WIDTH[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_exp_h = EXP_HEIGHT[c_cnt_w-1:0];

    sink_state_t r_state, w_state_nx;

    logic                 r_hs_prev, r_vs_prev;
    logic [c_cnt_w-1:0]   r_line_cnt, r_lines, r_width, r_hsyncs;
    logic                 r_width_set;
    logic                 r_done, r_err_w, r_err_h;
    logic [c_cksum_w-1:0] r_f_cksum;
    logic [c_cnt_w-1:0]   r_f_width, r_f_height, r_f_hsyncs;
    logic [15:0]          r_f_cnt;

    logic                 w_smp, w_act, w_hs, w_vs, w_hs_edge, w_vs_edge, w_in_frame;
    logic                 w_close, w_pix, w_line_err, w_frame_close;
    logic [c_cnt_w-1:0]   w_lines_nx, w_width_nx, w_hsyncs_nx;
    logic [c_cksum_w-1:0] w_acc;

    assign w_smp      = pix.pix_en_i;
    assign w_act      = (pix.blank_pad_i != BLANK_POL);
    assign w_hs       = (pix.hsync_pad_i == HSYNC_POL);
    assign w_vs       = (pix.vsync_pad_i == VSYNC_POL);
    assign w_hs_edge  = w_smp && w_hs && !r_hs_prev;
    assign w_vs_edge  = w_smp && w_vs && !r_vs_prev;
    assign w_in_frame = (r_state == ST_FRAME);

    // A vsync-edge sample only closes the open line; its own pixel is not accumulated.
    assign w_close       = w_in_frame && w_smp && (r_line_cnt != '0) && (!w_act || w_vs_edge);
    assign w_pix         = w_in_frame && w_smp && w_act && !w_vs_edge;
    assign w_line_err    = w_close && r_width_set && (r_line_cnt != r_width);
    assign w_frame_close = w_in_frame && w_vs_edge;

    assign w_lines_nx  = w_close ? sat_inc(r_lines) : r_lines;
    assign w_width_nx  = (w_close && !r_width_set) ? r_line_cnt : r_width;
    assign w_hsyncs_nx = (w_in_frame && w_hs_edge) ? sat_inc(r_hsyncs) : r_hsyncs;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_SEEK;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_vs_edge) begin
            w_state_nx = ST_FRAME;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_hs_prev   <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_line_cnt  <= '0;
            r_lines     <= '0;
            r_width     <= '0;
            r_width_set <= 1'b0;
            r_hsyncs    <= '0;
            r_done      <= 1'b0;
            r_err_w     <= 1'b0;
            r_err_h     <= 1'b0;
            r_f_cksum   <= '0;
            r_f_width   <= '0;
            r_f_height  <= '0;
            r_f_hsyncs  <= '0;
            r_f_cnt     <= '0;
        end else begin
            r_done <= w_frame_close;
            if (w_smp) begin
                r_hs_prev <= w_hs;
                r_vs_prev <= w_vs;
                if (w_vs_edge) begin
                    r_line_cnt  <= '0;
                    r_lines     <= '0;
                    r_width     <= '0;
                    r_width_set <= 1'b0;
                    r_hsyncs    <= '0;
                end else if (w_in_frame) begin
                    if (w_close) begin
                        r_line_cnt <= '0;
                    end else if (w_pix) begin
                        r_line_cnt <= sat_inc(r_line_cnt);
                    end
                    r_lines     <= w_lines_nx;
                    r_width     <= w_width_nx;
                    r_width_set <= r_width_set || w_close;
                    r_hsyncs    <= w_hsyncs_nx;
                end
                if (w_frame_close) begin
                    r_f_cksum  <= w_acc;
                    r_f_width  <= w_width_nx;
                    r_f_height <= w_lines_nx;
                    r_f_hsyncs <= w_hsyncs_nx;
                    r_f_cnt    <= r_f_cnt + 16'd1;
                    r_err_w    <= r_err_w || w_line_err || (w_width_nx != c_exp_w);
                    r_err_h    <= r_err_h || (w_lines_nx != c_exp_h);
                end else if (w_line_err) begin
                    r_err_w    <= 1'b1;
                end
            end
        end
    end

    vga_sink_cksum u_cksum (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .i_en  (w_pix),
        .i_clr (w_vs_edge),
        .i_rgb ({pix.r_pad_i, pix.g_pad_i, pix.b_pad_i}),
        .o_acc (w_acc)
    );

    assign frame_done_o   = r_done;
    assign frame_cksum_o  = r_f_cksum;
    assign frame_width_o  = r_f_width;
    assign frame_height_o = r_f_height;
    assign frame_hsyncs_o = r_f_hsyncs;
    assign frame_cnt_o    = r_f_cnt;
    assign locked_o       = w_in_frame;
    assign err_width_o    = r_err_w;
    assign err_height_o   = r_err_h;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
// ============================================================================
//  Module      : tb_vga_pixel_sink
//  Description : Self-checking bench for vga_pixel_sink (EXP 4x3, active-low pads).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_done, locked, err_w, err_h;
    logic [31:0] f_cksum;
    logic [11:0] f_width, f_height, f_hsyncs;
    logic [15:0] f_cnt;

    vga_pixel_sink_if pif();

    vga_pixel_sink #(.EXP_WIDTH(4), .EXP_HEIGHT(3)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .pix            (pif),
        .frame_done_o   (frame_done),
        .frame_cksum_o  (f_cksum),
        .frame_width_o  (f_width),
        .frame_height_o (f_height),
        .frame_hsyncs_o (f_hsyncs),
        .frame_cnt_o    (f_cnt),
        .locked_o       (locked),
        .err_width_o    (err_w),
        .err_height_o   (err_h)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_pulses = 0;
    int exp_pulses = 0;
    bit toggle_mode = 1'b0;

    always @(posedge clk) if (frame_done === 1'b1) n_pulses++;

    // Frame description and the expected results of the last closed frame.
    int          q_lens[$];
    logic [23:0] q_pix[$];
    logic [31:0] m_cksum;
    int          m_w, m_h, m_hs, m_cnt;
    bit          m_ew, m_eh;

    typedef struct {
        int nl; int len; int bad_idx; int bad_len; int pmode;
        bit tog; bit open_end; bit hs_at_vs;
        int exp_w; int exp_h; bit exp_ew; bit exp_eh;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic smp(input bit hs, input bit vs, input bit act, input logic [23:0] rgb);
        if (toggle_mode) begin
            @(negedge clk);
            pif.pix_en_i    = 1'b0;
            pif.hsync_pad_i = 1'($urandom);
            pif.vsync_pad_i = 1'($urandom);
            pif.blank_pad_i = 1'($urandom);
            {pif.r_pad_i, pif.g_pad_i, pif.b_pad_i} = 24'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        pif.pix_en_i    = 1'b1;
        pif.hsync_pad_i = !hs;
        pif.vsync_pad_i = !vs;
        pif.blank_pad_i = act;
        {pif.r_pad_i, pif.g_pad_i, pif.b_pad_i} = rgb;
        @(posedge clk);
        #1;
        pif.pix_en_i = 1'b0;
    endtask

    task automatic build(input int nl, input int len, input int bad_idx, input int bad_len,
                         input int pmode);
        q_lens.delete();
        q_pix.delete();
        for (int l = 0; l < nl; l++) begin
            int n;
            n = (l == bad_idx) ? bad_len : len;
            q_lens.push_back(n);
            for (int x = 0; x < n; x++) begin
                case (pmode)
                    0:       q_pix.push_back(24'(x));
                    1:       q_pix.push_back(24'($urandom));
                    default: q_pix.push_back(24'h010203);
                endcase
            end
        end
    endtask

    task automatic send_body(input bit open_end);
        int k;
        k = 0;
        smp(0, 0, 0, 24'h0);
        foreach (q_lens[l]) begin
            smp(1, 0, 0, 24'h0);
            smp(0, 0, 0, 24'h0);
            for (int x = 0; x < q_lens[l]; x++) begin
                smp(0, 0, 1, q_pix[k]);
                k++;
            end
            if (!(open_end && l == q_lens.size() - 1)) smp(0, 0, 0, 24'h0);
        end
    endtask

    task automatic check_outputs(input bit exp_done);
        chk("frame_done", {31'h0, frame_done}, {31'h0, exp_done});
        chk("locked", {31'h0, locked}, 32'h1);
        chk("width", {20'h0, f_width}, 32'(m_w));
        chk("height", {20'h0, f_height}, 32'(m_h));
        chk("hsyncs", {20'h0, f_hsyncs}, 32'(m_hs));
        chk("cksum", f_cksum, m_cksum);
        chk("frame_cnt", {16'h0, f_cnt}, 32'(m_cnt));
        chk("err_width", {31'h0, err_w}, {31'h0, m_ew});
        chk("err_height", {31'h0, err_h}, {31'h0, m_eh});
    endtask

    // Closing vsync; when expect_done the model derives the report from the frame description.
    task automatic do_vsync(input bit hs_too, input bit act, input bit expect_done);
        chk("pulse_count", 32'(n_pulses), 32'(exp_pulses));
        smp(hs_too, 1, act, 24'($urandom));
        if (expect_done) begin
            m_h  = q_lens.size();
            m_w  = (m_h > 0) ? q_lens[0] : 0;
            m_hs = m_h + (hs_too ? 1 : 0);
            m_cksum = 32'h0;
            foreach (q_pix[i]) m_cksum = {m_cksum[30:0], m_cksum[31]} ^ {8'h00, q_pix[i]};
            foreach (q_lens[i]) if (q_lens[i] != m_w) m_ew = 1'b1;
            if (m_w != 4) m_ew = 1'b1;
            if (m_h != 3) m_eh = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
            exp_pulses++;
        end
        check_outputs(expect_done);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pif.pix_en_i    = 1'($urandom);
        pif.vsync_pad_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pif.pix_en_i = 1'b0;
        m_cksum = 32'h0; m_w = 0; m_h = 0; m_hs = 0; m_cnt = 0; m_ew = 1'b0; m_eh = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_done", {31'h0, frame_done}, 32'h0);
        chk("rst_locked", {31'h0, locked}, 32'h0);
        chk("rst_outs", {f_cksum ^ {f_width, f_height, f_hsyncs[7:0]}}, 32'h0);
        chk("rst_misc", {12'h0, f_hsyncs[11:8], f_cnt}, 32'h0);
        chk("rst_errs", {30'h0, err_w, err_h}, 32'h0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{3, 4, -1, 0, 0, 1'b1, 1'b0, 1'b0, 4, 3, 1'b0, 1'b0};
        vecs[1] = '{3, 4, -1, 0, 1, 1'b0, 1'b1, 1'b1, 4, 3, 1'b0, 1'b0};
        vecs[2] = '{3, 4,  1, 3, 0, 1'b0, 1'b0, 1'b0, 4, 3, 1'b1, 1'b0};
        vecs[3] = '{3, 4, -1, 0, 0, 1'b1, 1'b0, 1'b0, 4, 3, 1'b1, 1'b0};
        vecs[4] = '{1, 1, -1, 0, 2, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1, 1'b1};
        vecs[5] = '{0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1};
        vecs[6] = '{2, 4, -1, 0, 0, 1'b1, 1'b1, 1'b0, 4, 2, 1'b1, 1'b1};

        pif.pix_en_i = 1'b0; pif.hsync_pad_i = 1'b1; pif.vsync_pad_i = 1'b1;
        pif.blank_pad_i = 1'b0; pif.r_pad_i = 8'h0; pif.g_pad_i = 8'h0; pif.b_pad_i = 8'h0;

        do_reset();
        check_reset_state();

        // Lock, then one 4x3 frame of pixel value = x closed by the second vsync.
        smp(0, 0, 0, 24'h0);
        do_vsync(0, 0, 0);
        build(3, 4, -1, 0, 0);
        send_body(0);
        do_vsync(0, 0, 1);
        chk("req27_width", {20'h0, f_width}, 32'd4);
        chk("req27_height", {20'h0, f_height}, 32'd3);
        chk("req27_cnt", {16'h0, f_cnt}, 32'd1);

        foreach (vecs[i]) begin
            toggle_mode = vecs[i].tog;
            build(vecs[i].nl, vecs[i].len, vecs[i].bad_idx, vecs[i].bad_len, vecs[i].pmode);
            send_body(vecs[i].open_end);
            do_vsync(vecs[i].hs_at_vs, vecs[i].open_end, 1);
            chk("vec_width", {20'h0, f_width}, 32'(vecs[i].exp_w));
            chk("vec_height", {20'h0, f_height}, 32'(vecs[i].exp_h));
            chk("vec_errs", {30'h0, err_w, err_h}, {30'h0, vecs[i].exp_ew, vecs[i].exp_eh});
            if (vecs[i].pmode == 2) chk("single_px_cksum", f_cksum, 32'h0001_0203);
        end
        toggle_mode = 1'b0;

        do_reset();
        check_reset_state();
        smp(0, 0, 0, 24'h0);
        do_vsync(0, 0, 0);

        for (int f = 0; f < 8; f++) begin
            int nl, len;
            toggle_mode = 1'($urandom);
            nl  = $urandom_range(0, 4);
            len = $urandom_range(1, 6);
            build(nl, len, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                  $urandom_range(1, 6), 1);
            send_body(1'($urandom));
            do_vsync(1'($urandom), 1'b0, 1);
        end
        toggle_mode = 1'b0;

        // Reset in the middle of a frame discards it; the next vsync only relocks.
        build(2, 4, -1, 0, 0);
        send_body(1);
        do_reset();
        check_reset_state();
        smp(0, 0, 0, 24'h0);
        do_vsync(0, 0, 0);
        build(3, 4, -1, 0, 0);
        send_body(0);
        do_vsync(0, 0, 1);
        chk("relock_cnt", {16'h0, f_cnt}, 32'd1);

        smp(0, 0, 0, 24'h0);
        smp(0, 0, 0, 24'h0);
        chk("final_pulses", 32'(n_pulses), 32'(exp_pulses));
        chk("final_done_low", {31'h0, frame_done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
